// File: rtl/video_host_regs.sv
// Host-side register window for the video core: scroll/address state (v, t, fine_x, w),
// status flags with NMI, OAM port, and a small FSM that sequences cart accesses for reg7.
module video_host_regs #(
   parameter int P_vblank_line    = 241,
   parameter int P_prerender_line = 261,
   parameter int P_cart_width     = 14,
   parameter int P_cart_latency   = 2
) (
   input  logic                    I_clock,
   input  logic                    I_reset,
   input  logic [2:0]              I_host_addr,
   input  logic                    I_host_wren,
   input  logic                    I_host_rden,
   input  logic [7:0]              I_host_data,
   output logic [7:0]              O_host_data,
   output logic                    O_host_nmi,
   input  logic [15:0]             I_hcount,
   input  logic [15:0]             I_vcount,
   input  logic                    I_spr0_hit,
   input  logic                    I_spr_ovf,
   output logic [7:0]              O_ctrl,
   output logic [7:0]              O_mask,
   output logic [P_cart_width:0]   O_v,
   output logic [P_cart_width:0]   O_t,
   output logic [2:0]              O_fine_x,
   output logic [7:0]              O_oam_addr,
   output logic                    O_oam_wren,
   output logic [7:0]              O_oam_data,
   input  logic [7:0]              I_oam_data,
   output logic [P_cart_width-1:0] O_cart_addr,
   output logic                    O_cart_wren,
   output logic                    O_cart_rden,
   output logic [7:0]              O_cart_data,
   input  logic [7:0]              I_cart_data,
   output logic                    O_busy
);

   localparam int LP_VW = P_cart_width + 1;

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_WAIT} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_wren_d;
   logic               r_rden_d;
   logic [7:0]         r_ctrl;
   logic [7:0]         r_mask;
   logic [LP_VW-1:0]   r_v;
   logic [LP_VW-1:0]   r_t;
   logic [2:0]         r_fine_x;
   logic               r_w;
   logic [7:0]         r_oam_addr;
   logic               r_oam_wren;
   logic [7:0]         r_oam_data;
   logic [7:0]         r_latch;
   logic [7:0]         r_buf;
   logic [7:0]         r_host_data;
   logic [7:0]         r_cart_wdata;
   logic               r_vblank;
   logic               r_spr0;
   logic               r_ovf;
   logic               r_nmi;
   logic [2:0]         r_wait_cnt;

   logic               w_wr_req;
   logic               w_rd_req;
   logic               w_r7_wr;
   logic               w_r7_rd;
   logic               w_stat_rd;
   logic               w_vbl_set;
   logic               w_pre_clr;
   logic [LP_VW-1:0]   w_inc;
   logic               w_cart_wren;
   logic               w_cart_rden;
   logic               w_v_step;
   logic               w_buf_load;

   // A write edge masks a coincident read edge.
   assign w_wr_req  = I_host_wren & ~r_wren_d;
   assign w_rd_req  = I_host_rden & ~r_rden_d & ~w_wr_req;
   assign w_r7_wr   = w_wr_req && (I_host_addr == 3'd7) && (r_state == S_IDLE);
   assign w_r7_rd   = w_rd_req && (I_host_addr == 3'd7) && (r_state == S_IDLE);
   assign w_stat_rd = w_rd_req && (I_host_addr == 3'd2);
   assign w_vbl_set = (I_vcount == 16'(P_vblank_line)) && (I_hcount == 16'd1);
   assign w_pre_clr = (I_vcount == 16'(P_prerender_line)) && (I_hcount == 16'd1);
   assign w_inc     = r_ctrl[2] ? LP_VW'(32) : LP_VW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cart_wren = 1'b0;
      w_cart_rden = 1'b0;
      w_v_step    = 1'b0;
      w_buf_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_r7_wr)      w_state_nxt = S_WR;
            else if (w_r7_rd) w_state_nxt = S_RD;
         end
         S_WR: begin
            w_cart_wren = 1'b1;
            w_v_step    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_RD: begin
            w_cart_rden = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_wait_cnt == 3'd0) begin
               w_buf_load  = 1'b1;
               w_v_step    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge I_clock) begin
      if (I_reset) begin
         r_wren_d     <= 1'b0;
         r_rden_d     <= 1'b0;
         r_ctrl       <= '0;
         r_mask       <= '0;
         r_v          <= '0;
         r_t          <= '0;
         r_fine_x     <= '0;
         r_w          <= 1'b0;
         r_oam_addr   <= '0;
         r_oam_wren   <= 1'b0;
         r_oam_data   <= '0;
         r_latch      <= '0;
         r_buf        <= '0;
         r_host_data  <= '0;
         r_cart_wdata <= '0;
         r_vblank     <= 1'b0;
         r_spr0       <= 1'b0;
         r_ovf        <= 1'b0;
         r_nmi        <= 1'b0;
         r_wait_cnt   <= '0;
      end else begin
         r_wren_d   <= I_host_wren;
         r_rden_d   <= I_host_rden;
         r_oam_wren <= 1'b0;
         r_nmi      <= r_vblank & r_ctrl[7];

         if (r_state == S_RD)
            r_wait_cnt <= 3'(P_cart_latency - 1);
         else if (r_state == S_WAIT && r_wait_cnt != 3'd0)
            r_wait_cnt <= r_wait_cnt - 3'd1;

         if (w_v_step)   r_v   <= r_v + w_inc;
         if (w_buf_load) r_buf <= I_cart_data;

         // A status read on the set clock both reports 0 and cancels this frame's set.
         if (w_pre_clr) begin
            r_vblank <= 1'b0;
            r_spr0   <= 1'b0;
            r_ovf    <= 1'b0;
         end else begin
            if (w_stat_rd)      r_vblank <= 1'b0;
            else if (w_vbl_set) r_vblank <= 1'b1;
            if (I_spr0_hit) r_spr0 <= 1'b1;
            if (I_spr_ovf)  r_ovf  <= 1'b1;
         end

         if (w_wr_req) begin
            r_latch <= I_host_data;
            case (I_host_addr)
               3'd0: begin
                  r_ctrl      <= I_host_data;
                  r_t[11:10]  <= I_host_data[1:0];
               end
               3'd1: r_mask <= I_host_data;
               3'd3: r_oam_addr <= I_host_data;
               3'd4: begin
                  r_oam_wren <= 1'b1;
                  r_oam_data <= I_host_data;
                  r_oam_addr <= r_oam_addr + 8'd1;
               end
               3'd5: begin
                  if (!r_w) begin
                     r_t[4:0] <= I_host_data[7:3];
                     r_fine_x <= I_host_data[2:0];
                  end else begin
                     r_t[14:12] <= I_host_data[2:0];
                     r_t[9:5]   <= I_host_data[7:3];
                  end
                  r_w <= ~r_w;
               end
               3'd6: begin
                  if (!r_w) begin
                     r_t[13:8] <= I_host_data[5:0];
                     r_t[14]   <= 1'b0;
                  end else begin
                     r_t[7:0] <= I_host_data;
                     r_v      <= {r_t[LP_VW-1:8], I_host_data};
                  end
                  r_w <= ~r_w;
               end
               3'd7: if (r_state == S_IDLE) r_cart_wdata <= I_host_data;
               default: ;
            endcase
         end else if (w_rd_req) begin
            case (I_host_addr)
               3'd2: begin
                  r_host_data <= {r_vblank, r_spr0, r_ovf, r_latch[4:0]};
                  r_w         <= 1'b0;
               end
               3'd4:    r_host_data <= I_oam_data;
               3'd7:    r_host_data <= r_buf;
               default: r_host_data <= r_latch;
            endcase
         end
      end
   end

   assign O_host_data = r_host_data;
   assign O_host_nmi  = r_nmi;
   assign O_ctrl      = r_ctrl;
   assign O_mask      = r_mask;
   assign O_v         = r_v;
   assign O_t         = r_t;
   assign O_fine_x    = r_fine_x;
   assign O_oam_addr  = r_oam_addr;
   assign O_oam_wren  = r_oam_wren;
   assign O_oam_data  = r_oam_data;
   assign O_cart_addr = r_v[P_cart_width-1:0];
   assign O_cart_wren = w_cart_wren;
   assign O_cart_rden = w_cart_rden;
   assign O_cart_data = r_cart_wdata;
   assign O_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_video_host_regs.sv
// Bench for video_host_regs: vector table of host accesses plus hand sequences for
// cart FSM timing, OAM wrap, vblank/NMI, strobe edges and reset during an access.
module tb_video_host_regs;

   logic        clk;
   logic        I_reset;
   logic [2:0]  I_host_addr;
   logic        I_host_wren;
   logic        I_host_rden;
   logic [7:0]  I_host_data;
   logic [7:0]  O_host_data;
   logic        O_host_nmi;
   logic [15:0] I_hcount;
   logic [15:0] I_vcount;
   logic        I_spr0_hit;
   logic        I_spr_ovf;
   logic [7:0]  O_ctrl;
   logic [7:0]  O_mask;
   logic [14:0] O_v;
   logic [14:0] O_t;
   logic [2:0]  O_fine_x;
   logic [7:0]  O_oam_addr;
   logic        O_oam_wren;
   logic [7:0]  O_oam_data;
   logic [7:0]  I_oam_data;
   logic [13:0] O_cart_addr;
   logic        O_cart_wren;
   logic        O_cart_rden;
   logic [7:0]  O_cart_data;
   logic [7:0]  I_cart_data;
   logic        O_busy;

   video_host_regs #(
      .P_vblank_line(241), .P_prerender_line(261), .P_cart_width(14), .P_cart_latency(2)
   ) dut (
      .I_clock(clk), .I_reset(I_reset),
      .I_host_addr(I_host_addr), .I_host_wren(I_host_wren), .I_host_rden(I_host_rden),
      .I_host_data(I_host_data), .O_host_data(O_host_data), .O_host_nmi(O_host_nmi),
      .I_hcount(I_hcount), .I_vcount(I_vcount), .I_spr0_hit(I_spr0_hit), .I_spr_ovf(I_spr_ovf),
      .O_ctrl(O_ctrl), .O_mask(O_mask), .O_v(O_v), .O_t(O_t), .O_fine_x(O_fine_x),
      .O_oam_addr(O_oam_addr), .O_oam_wren(O_oam_wren), .O_oam_data(O_oam_data),
      .I_oam_data(I_oam_data), .O_cart_addr(O_cart_addr), .O_cart_wren(O_cart_wren),
      .O_cart_rden(O_cart_rden), .O_cart_data(O_cart_data), .I_cart_data(I_cart_data),
      .O_busy(O_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q [$];

   // Cart model: two-clock read pipeline; 8'hEE marks cycles with no read in flight.
   function automatic logic [7:0] cart_mem(input logic [13:0] a);
      return (a == 14'h2109) ? 8'h5C : (a[7:0] ^ 8'hA5);
   endfunction

   logic        cart_req;
   logic [13:0] cart_req_addr;
   logic [7:0]  cart_p0, cart_p1;
   initial begin cart_req = 1'b0; cart_req_addr = '0; end
   always @(posedge clk) begin
      cart_p0 <= cart_req ? cart_mem(cart_req_addr) : 8'hEE;
      cart_p1 <= cart_p0;
   end
   assign I_cart_data = cart_p1;

   int          wr_cnt = 0, rd_cnt = 0, busy_cnt = 0;
   logic [13:0] wr_addr [4];
   logic [7:0]  wr_data [4];
   logic [13:0] rd_addr [4];
   always @(negedge clk) begin
      cart_req      = O_cart_rden;
      cart_req_addr = O_cart_addr;
      if (O_busy) busy_cnt++;
      if (O_cart_wren) begin
         if (wr_cnt < 4) begin wr_addr[wr_cnt] = O_cart_addr; wr_data[wr_cnt] = O_cart_data; end
         wr_cnt++;
      end
      if (O_cart_rden) begin
         if (rd_cnt < 4) rd_addr[rd_cnt] = O_cart_addr;
         rd_cnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic host_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      I_host_addr = a; I_host_data = d; I_host_wren = 1'b1;
      @(negedge clk);
      I_host_wren = 1'b0;
   endtask

   task automatic host_read(input logic [2:0] a, input logic [7:0] exp);
      @(negedge clk);
      I_host_addr = a; I_host_rden = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      I_host_rden = 1'b0;
      chk($sformatf("rd_reg%0d", a), 32'(O_host_data), 32'(exp_q.pop_front()));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (O_busy && n < 20) begin @(negedge clk); n++; end
      if (O_busy) chk("busy_timeout", 32'(O_busy), 32'd0);
   endtask

   typedef struct {
      bit          rd;
      logic [2:0]  addr;
      logic [7:0]  d;
      logic [7:0]  exp_rd;
      logic [14:0] exp_t;
      logic [14:0] exp_v;
      logic [2:0]  exp_fx;
   } vec_t;
   localparam int NV = 23;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_snap;
      vecs[0]  = '{1'b1, 3'd2, 8'h00, 8'h00, 15'h0000, 15'h0000, 3'd0};
      vecs[1]  = '{1'b0, 3'd6, 8'h21, 8'h00, 15'h2100, 15'h0000, 3'd0};
      vecs[2]  = '{1'b0, 3'd6, 8'h08, 8'h00, 15'h2108, 15'h2108, 3'd0};
      vecs[3]  = '{1'b0, 3'd7, 8'hAA, 8'h00, 15'h2108, 15'h2109, 3'd0};
      vecs[4]  = '{1'b0, 3'd0, 8'h04, 8'h00, 15'h2108, 15'h2109, 3'd0};
      vecs[5]  = '{1'b0, 3'd7, 8'hBB, 8'h00, 15'h2108, 15'h2129, 3'd0};
      vecs[6]  = '{1'b0, 3'd0, 8'h00, 8'h00, 15'h2108, 15'h2129, 3'd0};
      vecs[7]  = '{1'b0, 3'd6, 8'h21, 8'h00, 15'h2108, 15'h2129, 3'd0};
      vecs[8]  = '{1'b0, 3'd6, 8'h09, 8'h00, 15'h2109, 15'h2109, 3'd0};
      vecs[9]  = '{1'b1, 3'd7, 8'h00, 8'h00, 15'h2109, 15'h210A, 3'd0};
      vecs[10] = '{1'b1, 3'd7, 8'h00, 8'h5C, 15'h2109, 15'h210B, 3'd0};
      vecs[11] = '{1'b1, 3'd7, 8'h00, 8'hAF, 15'h2109, 15'h210C, 3'd0};
      vecs[12] = '{1'b0, 3'd5, 8'h7D, 8'h00, 15'h210F, 15'h210C, 3'd5};
      vecs[13] = '{1'b0, 3'd5, 8'h5E, 8'h00, 15'h616F, 15'h210C, 3'd5};
      vecs[14] = '{1'b1, 3'd5, 8'h00, 8'h5E, 15'h616F, 15'h210C, 3'd5};
      vecs[15] = '{1'b1, 3'd2, 8'h00, 8'h1E, 15'h616F, 15'h210C, 3'd5};
      vecs[16] = '{1'b0, 3'd6, 8'h3F, 8'h00, 15'h3F6F, 15'h210C, 3'd5};
      vecs[17] = '{1'b1, 3'd2, 8'h00, 8'h1F, 15'h3F6F, 15'h210C, 3'd5};
      vecs[18] = '{1'b0, 3'd6, 8'h12, 8'h00, 15'h126F, 15'h210C, 3'd5};
      vecs[19] = '{1'b0, 3'd6, 8'h34, 8'h00, 15'h1234, 15'h1234, 3'd5};
      vecs[20] = '{1'b0, 3'd3, 8'hFE, 8'h00, 15'h1234, 15'h1234, 3'd5};
      vecs[21] = '{1'b1, 3'd4, 8'h00, 8'h6D, 15'h1234, 15'h1234, 3'd5};
      vecs[22] = '{1'b1, 3'd0, 8'h00, 8'hFE, 15'h1234, 15'h1234, 3'd5};

      I_reset = 1'b1; I_host_addr = '0; I_host_wren = 1'b0; I_host_rden = 1'b0;
      I_host_data = '0; I_hcount = '0; I_vcount = '0; I_spr0_hit = 1'b0; I_spr_ovf = 1'b0;
      I_oam_data = 8'h6D;
      repeat (3) @(negedge clk);
      I_reset = 1'b0;
      @(negedge clk);
      chk("rst_host_data", 32'(O_host_data), 32'd0);
      chk("rst_ctrl_mask_nmi", {O_ctrl, O_mask, 7'd0, O_host_nmi}, 32'd0);
      chk("rst_v_t", {1'b0, O_v, 1'b0, O_t}, 32'd0);
      chk("rst_fx_oam", {O_fine_x, O_oam_addr, O_oam_wren, O_oam_data}, 32'd0);
      chk("rst_cart", {O_cart_addr, O_cart_wren, O_cart_rden, O_cart_data, O_busy}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rd) host_read(vecs[i].addr, vecs[i].exp_rd);
         else            host_write(vecs[i].addr, vecs[i].d);
         wait_idle();
         chk($sformatf("vec%0d_t", i),  32'(O_t),      32'(vecs[i].exp_t));
         chk($sformatf("vec%0d_v", i),  32'(O_v),      32'(vecs[i].exp_v));
         chk($sformatf("vec%0d_fx", i), 32'(O_fine_x), 32'(vecs[i].exp_fx));
      end

      chk("cart_wr_count", wr_cnt, 2);
      chk("cart_wr0", {wr_addr[0], wr_data[0]}, {14'h2108, 8'hAA});
      chk("cart_wr1", {wr_addr[1], wr_data[1]}, {14'h2109, 8'hBB});
      chk("cart_rd_count", rd_cnt, 3);
      chk("cart_rd0_addr", 32'(rd_addr[0]), 32'h2109);
      chk("cart_rd2_addr", 32'(rd_addr[2]), 32'h210B);

      // Busy lasts one RD clock plus the latency.
      busy_cnt = 0;
      host_read(3'd7, 8'hAE);
      wait_idle();
      chk("busy_cycles", busy_cnt, 3);
      chk("v_after_rd", 32'(O_v), 32'h1235);

      // Reg7 write while the read is in flight is dropped.
      host_read(3'd7, 8'h91);
      host_write(3'd7, 8'hC3);
      wait_idle();
      chk("busy_wr_dropped", wr_cnt, 2);
      chk("busy_wr_v", 32'(O_v), 32'h1236);
      host_read(3'd7, 8'h90);
      wait_idle();
      chk("v_after_rd2", 32'(O_v), 32'h1237);

      // OAM: reg4 read does not increment, write wraps FF->00, held strobe writes once.
      chk("oam_no_inc", 32'(O_oam_addr), 32'hFE);
      host_write(3'd3, 8'hFF);
      host_write(3'd4, 8'h77);
      chk("oam_pulse", {O_oam_wren, O_oam_data, O_oam_addr}, {1'b1, 8'h77, 8'h00});
      @(negedge clk);
      chk("oam_pulse_end", 32'(O_oam_wren), 32'd0);
      @(negedge clk);
      I_host_addr = 3'd4; I_host_data = 8'h55; I_host_wren = 1'b1;
      repeat (3) @(negedge clk);
      I_host_wren = 1'b0;
      @(negedge clk);
      chk("oam_held_strobe", 32'(O_oam_addr), 32'h01);

      // Vblank and NMI.
      host_write(3'd0, 8'h80);
      @(negedge clk); I_vcount = 16'd241; I_hcount = 16'd1;
      @(negedge clk); I_hcount = 16'd2;
      chk("nmi_not_yet", 32'(O_host_nmi), 32'd0);
      @(negedge clk);
      chk("nmi_rise", 32'(O_host_nmi), 32'd1);
      host_write(3'd0, 8'h00);
      @(negedge clk);
      chk("nmi_ctrl_off", 32'(O_host_nmi), 32'd0);
      host_write(3'd0, 8'h80);
      @(negedge clk);
      chk("nmi_ctrl_reenable", 32'(O_host_nmi), 32'd1);
      host_read(3'd2, 8'h80);
      @(negedge clk);
      chk("nmi_after_status", 32'(O_host_nmi), 32'd0);

      // Sprite flags, then prerender clears everything.
      @(negedge clk); I_spr0_hit = 1'b1; I_spr_ovf = 1'b1;
      @(negedge clk); I_spr0_hit = 1'b0; I_spr_ovf = 1'b0;
      host_read(3'd2, 8'h60);
      @(negedge clk); I_vcount = 16'd241; I_hcount = 16'd1;
      @(negedge clk); I_hcount = 16'd2;
      @(negedge clk);
      chk("nmi_frame2", 32'(O_host_nmi), 32'd1);
      @(negedge clk); I_vcount = 16'd261; I_hcount = 16'd1;
      @(negedge clk); I_hcount = 16'd2;
      @(negedge clk);
      chk("nmi_prerender", 32'(O_host_nmi), 32'd0);
      host_read(3'd2, 8'h00);

      // Status read on the exact set clock suppresses vblank.
      @(negedge clk);
      I_vcount = 16'd241; I_hcount = 16'd1; I_host_addr = 3'd2; I_host_rden = 1'b1;
      exp_q.push_back(8'h00);
      @(negedge clk);
      I_hcount = 16'd2; I_host_rden = 1'b0;
      chk("rd_race_data", 32'(O_host_data), 32'(exp_q.pop_front()));
      repeat (3) @(negedge clk);
      chk("nmi_suppressed", 32'(O_host_nmi), 32'd0);
      host_read(3'd2, 8'h00);
      I_vcount = 16'd0;

      // Coincident read and write edges: write wins.
      @(negedge clk);
      I_host_addr = 3'd4; I_host_data = 8'h42; I_host_wren = 1'b1; I_host_rden = 1'b1;
      @(negedge clk);
      I_host_wren = 1'b0; I_host_rden = 1'b0;
      chk("rdwr_host_data", 32'(O_host_data), 32'h00);
      chk("rdwr_oam", {O_oam_wren, O_oam_data, O_oam_addr}, {1'b1, 8'h42, 8'h02});

      // Reset during a cart read.
      host_read(3'd7, 8'h93);
      I_reset = 1'b1;
      @(negedge clk);
      I_reset = 1'b0;
      chk("midrst_busy_rden", {O_busy, O_cart_rden}, 32'd0);
      rd_snap = rd_cnt;
      repeat (4) @(negedge clk);
      chk("midrst_no_strobe", rd_cnt, rd_snap);
      chk("midrst_regs", {1'b0, O_v, O_ctrl, O_oam_addr}, 32'd0);
      chk("midrst_out", {O_host_data, O_host_nmi}, 32'd0);
      host_read(3'd2, 8'h00);
      host_read(3'd7, 8'h00);
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
